// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq -- multicycle floating-point adder/subtractor (start/done coprocessor)
//
// Operands use the IEEE-754 layout {sign, exp[EXP_W-1:0], frac[MAN_W-1:0]}.
// The exponent bias is 2^(EXP_W-1)-1. Subnormals, infinities and NaNs are handled.
//
// Configuration macro: FP_ADDSUB_RNE_EN
//   defined   : round to nearest, ties to even; overflow gives a signed infinity
//   undefined : truncate toward zero; overflow saturates to the largest finite value
//   ovf and inexact are produced the same way in both builds.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   request; sampled only while idle (IDLE or DONE)
//   op       in   0 = a+b, 1 = a-b (sign of b inverted when captured)
//   a, b     in   operands
//   result   out  sum/difference, held until the next accepted start
//   done     out  high from completion until the next accepted start
//   busy     out  high in every state except IDLE/DONE
//   ovf      out  result overflowed (infinity or saturated); valid with done
//   inexact  out  guard/round/sticky bits were nonzero; valid with done
//
// Handshake: start is a level sampled on a rising clk edge while the unit is in
// IDLE or DONE. That edge captures a, b and op, drops done and raises busy. The
// result, ovf and inexact outputs are valid in every cycle where done is high.
// A start seen while busy is ignored.
//
// Flow: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// The FSM register is named `state`, and its state_t encoding is available for
// hierarchical probing.

module fp_addsub_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done,
    output logic                 busy,
    output logic                 ovf,
    output logic                 inexact
);

    localparam int W = 1 + EXP_W + MAN_W;
    // Aligned mantissa: hidden bit, fraction, guard, round, sticky.
    localparam int M = MAN_W + 4;
    // Adder width: one extra carry bit on top of the aligned mantissa.
    localparam int S = MAN_W + 5;
    // Beyond this distance, Y contributes only to the sticky bit.
    localparam int ALIGN_MAX = MAN_W + 3;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MIN  = EXP_W'(1);
    localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W + 1)'(1);
    localparam logic [EXP_W:0]   EXP_INF  = {1'b0, EXP_ONES};
    localparam logic [W-1:0]     NAN_CANON = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t state;

    // Captured operands; b_q already carries the op-adjusted sign.
    logic [W-1:0]     a_q, b_q;

    // Working datapath registers.
    logic             x_sign, y_sign;
    logic [EXP_W:0]   ex;          // one spare bit so exp+1 past all-ones is visible
    logic [M-1:0]     mx, my;
    logic [EXP_W-1:0] dcnt;        // remaining alignment shifts
    logic [S-1:0]     sum;
    logic             res_sign;

    // ------------------------------------------------------------------
    // Unpack: field split, special detection and magnitude ordering
    // ------------------------------------------------------------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf;

    assign a_sign = a_q[W-1];
    assign b_sign = b_q[W-1];
    assign a_exp  = a_q[W-2:MAN_W];
    assign b_exp  = b_q[W-2:MAN_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);

    logic             swap;
    logic             ux_sign, uy_sign;
    logic [EXP_W-1:0] ux_exp, uy_exp, ux_eff, uy_eff, exp_diff;
    logic [MAN_W-1:0] ux_frac, uy_frac;
    logic [M-1:0]     ux_mant, uy_mant;

    always_comb begin
        // {exp, frac} orders magnitudes correctly, subnormals included.
        swap = (b_q[W-2:0] > a_q[W-2:0]);
        if (swap) begin
            ux_sign = b_sign; ux_exp = b_exp; ux_frac = b_frac;
            uy_sign = a_sign; uy_exp = a_exp; uy_frac = a_frac;
        end else begin
            ux_sign = a_sign; ux_exp = a_exp; ux_frac = a_frac;
            uy_sign = b_sign; uy_exp = b_exp; uy_frac = b_frac;
        end
        // Subnormals share exponent 1 with the smallest normals, hidden bit 0.
        ux_eff   = (ux_exp == '0) ? EXP_MIN : ux_exp;
        uy_eff   = (uy_exp == '0) ? EXP_MIN : uy_exp;
        ux_mant  = {(ux_exp != '0), ux_frac, 3'b000};
        uy_mant  = {(uy_exp != '0), uy_frac, 3'b000};
        exp_diff = ux_eff - uy_eff;
    end

    logic         spec_hit;
    logic [W-1:0] spec_val;

    always_comb begin
        spec_hit = 1'b1;
        spec_val = NAN_CANON;
        if (a_nan || b_nan) begin
            spec_val = NAN_CANON;
        end else if (a_inf && b_inf && (a_sign != b_sign)) begin
            spec_val = NAN_CANON;
        end else if (a_inf) begin
            spec_val = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_val = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Add: X is the larger magnitude, so a subtraction never goes negative
    // ------------------------------------------------------------------
    logic [S-1:0] add_sum;

    always_comb begin
        if (x_sign != y_sign) add_sum = {1'b0, mx} - {1'b0, my};
        else                  add_sum = {1'b0, mx} + {1'b0, my};
    end

    // ------------------------------------------------------------------
    // Round: sum is normalised (or subnormal with ex == 1) on entry
    // ------------------------------------------------------------------
    logic [MAN_W:0]   rnd_mant;
    logic             rnd_g, rnd_r, rnd_s, rnd_up, rnd_inexact, rnd_ovf;
    logic [MAN_W+1:0] rnd_sum;
    logic [EXP_W:0]   rnd_exp;
    logic [MAN_W-1:0] rnd_frac;
    logic [W-1:0]     rnd_result;

    always_comb begin
        rnd_mant    = sum[S-2:3];
        rnd_g       = sum[2];
        rnd_r       = sum[1];
        rnd_s       = sum[0];
        rnd_inexact = rnd_g | rnd_r | rnd_s;
`ifdef FP_ADDSUB_RNE_EN
        // Above half an ulp, or exactly half with an odd lsb.
        rnd_up = rnd_g & (rnd_r | rnd_s | rnd_mant[0]);
`else
        rnd_up = 1'b0;
`endif
        rnd_sum = {1'b0, rnd_mant} + {{(MAN_W + 1){1'b0}}, rnd_up};
        if (rnd_sum[MAN_W+1]) begin
            // 1.11..1 rounded up to 10.00..0: renormalise by bumping the exponent.
            rnd_exp  = ex + EXP_ONE;
            rnd_frac = rnd_sum[MAN_W:1];
        end else begin
            // Hidden bit clear here only for a subnormal result (ex == 1).
            rnd_exp  = rnd_sum[MAN_W] ? ex : '0;
            rnd_frac = rnd_sum[MAN_W-1:0];
        end
        rnd_ovf = (rnd_exp >= EXP_INF);
        if (rnd_ovf) begin
`ifdef FP_ADDSUB_RNE_EN
            rnd_result = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
`else
            rnd_result = {res_sign, EXP_ONES - EXP_MIN, {MAN_W{1'b1}}};
`endif
        end else begin
            rnd_result = {res_sign, rnd_exp[EXP_W-1:0], rnd_frac};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            inexact  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            x_sign   <= 1'b0;
            y_sign   <= 1'b0;
            ex       <= '0;
            mx       <= '0;
            my       <= '0;
            dcnt     <= '0;
            sum      <= '0;
            res_sign <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= {b[W-1] ^ op, b[W-2:0]};
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    if (spec_hit) begin
                        result  <= spec_val;
                        ovf     <= 1'b0;
                        inexact <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        x_sign <= ux_sign;
                        y_sign <= uy_sign;
                        ex     <= {1'b0, ux_eff};
                        mx     <= ux_mant;
                        my     <= uy_mant;
                        dcnt   <= exp_diff;
                        state  <= (exp_diff == '0) ? S_ADD : S_ALIGN;
                    end
                end

                S_ALIGN: begin
                    if (32'(dcnt) > 32'(ALIGN_MAX)) begin
                        // Every bit of Y would fall past sticky anyway.
                        my    <= {{(M - 1){1'b0}}, |my};
                        state <= S_ADD;
                    end else begin
                        my   <= {1'b0, my[M-1:2], my[1] | my[0]};
                        dcnt <= dcnt - EXP_MIN;
                        if (dcnt == EXP_MIN) state <= S_ADD;
                    end
                end

                S_ADD: begin
                    if (add_sum == '0) begin
                        // Exact zero is +0 unless both inputs were -0.
                        result  <= {x_sign & y_sign, {(W - 1){1'b0}}};
                        ovf     <= 1'b0;
                        inexact <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        sum      <= add_sum;
                        res_sign <= x_sign;
                        state    <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (sum[S-1]) begin
                        sum   <= {1'b0, sum[S-1:2], sum[1] | sum[0]};
                        ex    <= ex + EXP_ONE;
                        state <= S_ROUND;
                    end else if (sum[S-2] || (ex == EXP_ONE)) begin
                        state <= S_ROUND;
                    end else begin
                        sum <= {sum[S-2:0], 1'b0};
                        ex  <= ex - EXP_ONE;
                    end
                end

                S_ROUND: begin
                    result  <= rnd_result;
                    ovf     <= rnd_ovf;
                    inexact <= rnd_inexact;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq -- self-checking bench for fp_addsub_seq (default parameters).
// The reference model evaluates each operation as an exact integer sum, then
// rounds it by the IEEE rules. Literal vectors pin the model itself.

module tb_fp_addsub_seq;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EMAX  = (1 << EXP_W) - 1;
    localparam int BOUND = 5 + 2 * (MAN_W + 3) + 3;

    localparam logic [W-1:0] NAN_C = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

`ifdef FP_ADDSUB_RNE_EN
    localparam logic [W-1:0] EXP_075 = 16'h3C01;
    localparam logic [W-1:0] EXP_TIE = 16'h3C02;
    localparam logic [W-1:0] EXP_OVF = 16'h7C00;
`else
    localparam logic [W-1:0] EXP_075 = 16'h3C00;
    localparam logic [W-1:0] EXP_TIE = 16'h3C01;
    localparam logic [W-1:0] EXP_OVF = 16'h7BFF;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b, result;
    logic         done, busy, ovf, inexact;

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf),
        .inexact (inexact)
    );

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];   // {ovf, inexact, result}

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                           input logic opi);
        logic         sa, sb, sgn, inx, ov;
        int           ea, eb, p, sh, e;
        longint       fa, fb, ma, mb, n, mag, kept, rem, half;
        logic [W-1:0] r;
        sa = ai[W-1];
        sb = bi[W-1] ^ opi;
        ea = int'(ai[W-2:MAN_W]);
        eb = int'(bi[W-2:MAN_W]);
        fa = longint'(ai[MAN_W-1:0]);
        fb = longint'(bi[MAN_W-1:0]);
        if ((ea == EMAX && fa != 0) || (eb == EMAX && fb != 0)) return {2'b00, NAN_C};
        if (ea == EMAX && eb == EMAX)
            return (sa != sb) ? {2'b00, NAN_C} : {2'b00, sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (ea == EMAX) return {2'b00, sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (eb == EMAX) return {2'b00, sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        // Values in units of the smallest subnormal.
        ma = (ea == 0) ? fa : ((fa + (longint'(1) << MAN_W)) << (ea - 1));
        mb = (eb == 0) ? fb : ((fb + (longint'(1) << MAN_W)) << (eb - 1));
        n  = (sa ? -ma : ma) + (sb ? -mb : mb);
        if (n == 0) return {2'b00, sa & sb, {(W - 1){1'b0}}};
        sgn = (n < 0);
        mag = sgn ? -n : n;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        inx = 1'b0;
        ov  = 1'b0;
        if (p <= MAN_W) begin
            r = {sgn, mag[W-2:0]};
        end else begin
            sh   = p - MAN_W;
            kept = mag >> sh;
            rem  = mag & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            e    = sh + 1;
            inx  = (rem != 0);
`ifdef FP_ADDSUB_RNE_EN
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            if (kept == (longint'(1) << (MAN_W + 1))) begin
                kept = kept >> 1;
                e    = e + 1;
            end
`endif
            if (e >= EMAX) begin
                ov = 1'b1;
`ifdef FP_ADDSUB_RNE_EN
                r = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
                r = {sgn, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
`endif
            end else begin
                r = {sgn, EXP_W'(e), kept[MAN_W-1:0]};
            end
        end
        return {ov, inx, r};
    endfunction

    // ---------------- scoreboard compare process ----------------
    initial begin : compare_proc
        logic [W+1:0] cur;
        logic         have_cur, done_prev;
        cur = '0;
        have_cur = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_cur  = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: got done=1, required no completion");
                        have_cur = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (done && have_cur) begin
                    check("scoreboard", {ovf, inexact, result}, cur);
                    check("busy_while_done", {{(W + 1){1'b0}}, busy}, '0);
                end
                done_prev = done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic opi,
                         input bit repulse, output int lat, output logic [W+1:0] got);
        @(negedge clk);
        exp_q.push_back(model(ai, bi, opi));
        a = ai;
        b = bi;
        op = opi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy_done", {{W{1'b0}}, busy, done}, {{W{1'b0}}, 2'b10});
        // Scramble inputs to confirm they were captured.
        a = W'($urandom);
        b = W'($urandom);
        op = ~opi;
        lat = 1;
        while (!done && lat < BOUND) begin
            start = (repulse && lat == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
        end
        got = {ovf, inexact, result};
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic opi, input logic [W-1:0] res, input logic o,
                       input logic ix, input int max_lat);
        int           lat;
        logic [W+1:0] got;
        check({name, "_model"}, model(ai, bi, opi), {o, ix, res});
        do_op(ai, bi, opi, 1'b0, lat, got);
        check(name, got, {o, ix, res});
        if (max_lat > 0) check({name, "_latency"}, W'(lat), W'(max_lat) - ((lat <= max_lat) ? W'(max_lat - lat) : '0));
    endtask

    function automatic logic [W-1:0] rand_fp();
        logic         s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        s = 1'($urandom);
        f = MAN_W'($urandom);
        case ($urandom_range(0, 9))
            0:       begin e = '1; if ($urandom_range(0, 1) == 0) f = '0; end
            1:       e = '0;
            default: e = EXP_W'($urandom_range(1, EMAX - 1));
        endcase
        return {s, e, f};
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main_proc
        int           lat;
        logic [W+1:0] got;
        logic [W-1:0] ra, rb;
        int           eb;
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {result, done, busy}, '0);
        check("reset_flags", {{W{1'b0}}, ovf, inexact}, '0);
        reset = 1'b0;

        pin("double",     16'h1A04, 16'h1A04, 1'b0, 16'h1E04, 1'b0, 1'b0, 6);
        pin("frac_075",   16'h3C00, 16'h1200, 1'b0, EXP_075,  1'b0, 1'b1, 0);
        pin("tie_odd",    16'h3C01, 16'h1000, 1'b0, EXP_TIE,  1'b0, 1'b1, 0);
        pin("cancel",     16'h4500, 16'h4500, 1'b1, 16'h0000, 1'b0, 1'b0, 0);
        pin("inf_m_inf",  16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b0, 0);
        pin("overflow",   16'h7BFF, 16'h7BFF, 1'b0, EXP_OVF,  1'b1, 1'b0, 0);
        pin("subnorm",    16'h0001, 16'h03FF, 1'b0, 16'h0400, 1'b0, 1'b0, 0);
        pin("neg_zeros",  16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 0);
        pin("mixed_zero", 16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        pin("nan_in",     16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 0);
        pin("inf_plus",   16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 0);

        // A start pulse while busy must not disturb the running operation.
        do_op(16'h3C00, 16'h1200, 1'b0, 1'b1, lat, got);
        check("restart_ignored", got, {2'b01, EXP_075});

        // Reset in the middle of alignment aborts at once.
        @(negedge clk);
        a = 16'h3C00;
        b = 16'h1200;
        op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outputs", {result, done, busy}, '0);
        check("abort_flags", {{W{1'b0}}, ovf, inexact}, '0);
        @(negedge clk);
        reset = 1'b0;
        pin("after_abort", 16'h3C01, 16'h1000, 1'b0, EXP_TIE, 1'b0, 1'b1, 0);

        // Randomised operations, biased toward alignment and cancellation.
        for (int i = 0; i < 400; i++) begin
            ra = rand_fp();
            case ($urandom_range(0, 3))
                0: rb = rand_fp();
                1: rb = {1'($urandom), ra[W-2:MAN_W], ra[MAN_W-1:0] ^ MAN_W'($urandom_range(0, 7))};
                2: begin
                    eb = int'(ra[W-2:MAN_W]) - int'($urandom_range(0, 16));
                    if (eb < 0) eb = 0;
                    rb = {1'($urandom), EXP_W'(eb), MAN_W'($urandom)};
                end
                default: rb = ra;
            endcase
            do_op(ra, rb, 1'($urandom), 1'b0, lat, got);
        end

        check("queue_drained", (W + 2)'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

endmodule
